// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine credit controller.
package vend_pkg;

  localparam int unsigned CREDIT_W = 7;

  typedef enum logic {
    IDLE,
    CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] COIN_10C_VAL  = 7'd1;
  localparam logic [CREDIT_W-1:0] COIN_50C_VAL  = 7'd5;
  localparam logic [CREDIT_W-1:0] COIN_100C_VAL = 7'd10;

  localparam int unsigned DEF_PRICE_APPLE  = 5;
  localparam int unsigned DEF_PRICE_BANANA = 3;
  localparam int unsigned DEF_PRICE_CARROT = 2;
  localparam int unsigned DEF_PRICE_DATE   = 7;
  localparam int unsigned DEF_CREDIT_MAX   = 99;

endpackage

// File: rtl/vend_credit_ctrl_bin2bcd99.sv
// Combinational 7-bit binary (0..99) to two-digit BCD converter.
module bin2bcd99
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] bin,
  output logic [7:0]          bcd
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens = '0;
    for (int unsigned t = 1; t < 10; t++) begin
      if (bin >= 7'(t * 10)) tens = 4'(t);
    end
    units = 4'(bin - 7'(tens) * 7'd10);
  end

  assign bcd = {tens, units};

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending-machine core: credit keeping, product dispense, refund sequencing, BCD credit out.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_APPLE  = DEF_PRICE_APPLE,
  parameter int unsigned PRICE_BANANA = DEF_PRICE_BANANA,
  parameter int unsigned PRICE_CARROT = DEF_PRICE_CARROT,
  parameter int unsigned PRICE_DATE   = DEF_PRICE_DATE,
  parameter int unsigned CREDIT_MAX   = DEF_CREDIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_10c,
  input  logic       coin_50c,
  input  logic       coin_100c,
  input  logic       sel_apple,
  input  logic       sel_banana,
  input  logic       sel_carrot,
  input  logic       sel_date,
  input  logic       cancel,
  output logic       apple,
  output logic       banana,
  output logic       carrot,
  output logic       date,
  output logic       error,
  output logic [7:0] credit,
  output logic       change_dime,
  output logic       coin_reject,
  output logic       busy
);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          disp_q, disp_d;
  logic                err_q, err_d;
  logic                reject_q, reject_d;
  logic                dime_q, dime_d;
  logic [7:0]          bcd_q, bcd_d;

  logic [3:0]          sel_vec;
  logic [2:0]          coin_vec;
  logic                sel_any, sel_multi, coin_any, coin_multi;
  logic [CREDIT_W-1:0] price, coin_val;

  assign sel_vec    = {sel_apple, sel_banana, sel_carrot, sel_date};
  assign coin_vec   = {coin_10c, coin_50c, coin_100c};
  assign sel_any    = |sel_vec;
  assign sel_multi  = |(sel_vec & (sel_vec - 4'd1));
  assign coin_any   = |coin_vec;
  assign coin_multi = |(coin_vec & (coin_vec - 3'd1));

  always_comb begin
    price = 7'(PRICE_DATE);
    if (sel_apple)       price = 7'(PRICE_APPLE);
    else if (sel_banana) price = 7'(PRICE_BANANA);
    else if (sel_carrot) price = 7'(PRICE_CARROT);
  end

  always_comb begin
    coin_val = COIN_100C_VAL;
    if (coin_10c)      coin_val = COIN_10C_VAL;
    else if (coin_50c) coin_val = COIN_50C_VAL;
  end

  // CHANGE is held for one extra cycle after the last dime so that busy and
  // change_dime are only ever seen together with the CHANGE state.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    disp_d   = '0;
    err_d    = 1'b0;
    reject_d = 1'b0;
    dime_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cancel && credit_q != '0) begin
          state_d  = CHANGE;
          credit_d = credit_q - 7'd1;
          dime_d   = 1'b1;
          reject_d = coin_any;
        end else if (sel_multi) begin
          err_d    = 1'b1;
          reject_d = coin_any;
        end else if (sel_any) begin
          reject_d = coin_any;
          if (credit_q >= price) begin
            credit_d = credit_q - price;
            disp_d   = sel_vec;
          end else begin
            err_d = 1'b1;
          end
        end else if (coin_multi) begin
          reject_d = 1'b1;
          err_d    = 1'b1;
        end else if (coin_any) begin
          if (credit_q + coin_val <= 7'(CREDIT_MAX)) begin
            credit_d = credit_q + coin_val;
          end else begin
            reject_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          credit_d = credit_q - 7'd1;
          dime_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bin2bcd99 u_bcd (
    .bin (credit_d),
    .bcd (bcd_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      disp_q   <= '0;
      err_q    <= 1'b0;
      reject_q <= 1'b0;
      dime_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      disp_q   <= disp_d;
      err_q    <= err_d;
      reject_q <= reject_d;
      dime_q   <= dime_d;
      bcd_q    <= bcd_d;
    end
  end

  assign {apple, banana, carrot, date} = disp_q;
  assign error       = err_q;
  assign coin_reject = reject_q;
  assign change_dime = dime_q;
  assign credit      = bcd_q;
  assign busy        = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: a behavioural model queues expected outputs per cycle.
module tb_vend_credit_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_10c = 1'b0, coin_50c = 1'b0, coin_100c = 1'b0;
  logic       sel_apple = 1'b0, sel_banana = 1'b0, sel_carrot = 1'b0, sel_date = 1'b0;
  logic       cancel = 1'b0;
  logic       apple, banana, carrot, date, error, change_dime, coin_reject, busy;
  logic [7:0] credit;

  // stimulus bits: {cancel, apple, banana, carrot, date, 10c, 50c, 100c}
  localparam logic [7:0] S_IDLE   = 8'h00;
  localparam logic [7:0] S_CANCEL = 8'h80;
  localparam logic [7:0] S_APPLE  = 8'h40;
  localparam logic [7:0] S_BANANA = 8'h20;
  localparam logic [7:0] S_CARROT = 8'h10;
  localparam logic [7:0] S_DATE   = 8'h08;
  localparam logic [7:0] S_C10    = 8'h04;
  localparam logic [7:0] S_C50    = 8'h02;
  localparam logic [7:0] S_C100   = 8'h01;

  logic [15:0] sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          m_credit = 0;
  bit          m_change = 1'b0;

  vend_credit_ctrl #(
    .PRICE_APPLE  (5),
    .PRICE_BANANA (3),
    .PRICE_CARROT (2),
    .PRICE_DATE   (7),
    .CREDIT_MAX   (99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_10c    (coin_10c),
    .coin_50c    (coin_50c),
    .coin_100c   (coin_100c),
    .sel_apple   (sel_apple),
    .sel_banana  (sel_banana),
    .sel_carrot  (sel_carrot),
    .sel_date    (sel_date),
    .cancel      (cancel),
    .apple       (apple),
    .banana      (banana),
    .carrot      (carrot),
    .date        (date),
    .error       (error),
    .credit      (credit),
    .change_dime (change_dime),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] observed();
    return {apple, banana, carrot, date, error, coin_reject, change_dime, busy, credit};
  endfunction

  // Behavioural reference: one call per clock, returns outputs expected after the edge.
  task automatic model_step(input logic [7:0] s, output logic [15:0] exp);
    logic [3:0] sel;
    logic [2:0] coin;
    logic [3:0] d;
    logic       e, r, dm;
    int         nsel, ncoin, p, v;
    sel   = s[6:3];
    coin  = s[2:0];
    nsel  = $countones(sel);
    ncoin = $countones(coin);
    d = '0; e = 1'b0; r = 1'b0; dm = 1'b0;
    if (m_change) begin
      r = (ncoin != 0);
      if (m_credit == 0) m_change = 1'b0;
      else begin m_credit--; dm = 1'b1; end
    end else if (s[7] && m_credit > 0) begin
      m_change = 1'b1; m_credit--; dm = 1'b1; r = (ncoin != 0);
    end else if (nsel >= 2) begin
      e = 1'b1; r = (ncoin != 0);
    end else if (nsel == 1) begin
      r = (ncoin != 0);
      p = sel[3] ? 5 : sel[2] ? 3 : sel[1] ? 2 : 7;
      if (m_credit >= p) begin m_credit -= p; d = sel; end
      else e = 1'b1;
    end else if (ncoin >= 2) begin
      r = 1'b1; e = 1'b1;
    end else if (ncoin == 1) begin
      v = coin[2] ? 1 : coin[1] ? 5 : 10;
      if (m_credit + v <= 99) m_credit += v;
      else begin r = 1'b1; e = 1'b1; end
    end
    exp = {d, e, r, dm, m_change, 4'(m_credit / 10), 4'(m_credit % 10)};
  endtask

  task automatic drive(input string tag, input logic [7:0] s);
    logic [15:0] e;
    {cancel, sel_apple, sel_banana, sel_carrot, sel_date, coin_10c, coin_50c, coin_100c} = s;
    model_step(s, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq(tag, observed(), sb_q.pop_front());
  endtask

  task automatic drive_idle(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(tag, S_IDLE);
  endtask

  initial begin
    logic [7:0] s;

    // reset held with toggling inputs
    for (int i = 0; i < 2; i++) begin
      {cancel, sel_apple, sel_banana, sel_carrot, sel_date, coin_10c, coin_50c, coin_100c} = 8'($urandom);
      @(posedge clk);
      #1;
      check_eq("reset", observed(), 16'h0000);
    end
    {cancel, sel_apple, sel_banana, sel_carrot, sel_date, coin_10c, coin_50c, coin_100c} = S_IDLE;
    reset = 1'b1;

    drive("buy_coin", S_C100);
    check_eq("buy_credit10", {8'h00, credit}, 16'h0010);
    drive("buy_apple", S_APPLE);
    check_eq("buy_credit05", {8'h00, credit}, 16'h0005);
    drive("buy_gap", S_IDLE);
    drive("banana", S_BANANA);
    drive("insuff_date", S_DATE);
    check_eq("insuff_err", {14'h0, error, date}, 16'h0002);

    drive("coin10", S_C10);
    drive("refund_cancel", S_CANCEL);
    drive_idle("refund", 3);
    check_eq("refund_done", {14'h0, busy, change_dime}, 16'h0000);

    for (int i = 0; i < 9; i++) drive("fill100", S_C100);
    drive("fill50", S_C50);
    drive("overflow", S_C100);
    check_eq("overflow_flags", {6'h0, coin_reject, error, credit}, 16'h0395);
    drive("dual_coin", S_C10 | S_C50);

    drive("refund95", S_CANCEL);
    for (int i = 0; i < 95; i++) drive("refund95_run", S_IDLE | (i == 20 ? S_C50 | S_APPLE : 8'h00));
    drive("coin100", S_C100);
    drive("dual_sel", S_APPLE | S_CARROT);
    check_eq("dual_sel_credit", {8'h00, credit}, 16'h0010);
    drive("apple2", S_APPLE);
    drive("banana2", S_BANANA);
    drive("coin_and_carrot", S_C10 | S_CARROT);
    check_eq("coin_carrot_out", {6'h0, carrot, coin_reject, credit}, 16'h0300);

    drive("fill50b", S_C50);
    drive_idle("fill10b", 0);
    for (int i = 0; i < 4; i++) drive("fill10b", S_C10);
    drive("mid_cancel", S_CANCEL);
    drive("mid_dime2", S_IDLE);
    reset = 1'b0;
    #1;
    check_eq("reset_mid", observed(), 16'h0000);
    m_credit = 0;
    m_change = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive("post_reset", S_C10);

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s[7] = ($urandom_range(0, 40) == 0);
      for (int b = 0; b < 7; b++) s[b] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) s[6:3] = '0;
      drive("random", s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
